// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job controller: state encodings,
// output-geometry helpers and the default MAC timeout.
package cnn_pkg;

    localparam int unsigned DEF_TIMEOUT = 1024;

    // FSM state encodings (legacy-compatible constants).
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_GUARD   = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_ADVANCE = 3'd4;
    localparam state_t ST_FIN     = 3'd5;

    // Number of valid window positions along one image edge.
    function automatic int unsigned out_dim(input int unsigned img, input int unsigned n);
        return img - n + 1;
    endfunction

    // Total MAC jobs for one run.
    function automatic int unsigned job_count(input int unsigned ow, input int unsigned oh,
                                              input int unsigned filters);
        return ow * oh * filters;
    endfunction

    // Index width for a range of n values; never zero so degenerate
    // (single-position) dimensions still get a real 1-bit port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_job_ctrl_if.sv
// MAC-facing start/ready handshake plus the window/filter indices of the
// job in flight. master = job controller, slave = MAC.
interface mac_job_ctrl_if
    import cnn_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned IMG_W   = 6,
    parameter int unsigned IMG_H   = 6,
    parameter int unsigned FILTERS = 2
) ();

    localparam int unsigned ROW_W  = idx_w(out_dim(IMG_H, N));
    localparam int unsigned COL_W  = idx_w(out_dim(IMG_W, N));
    localparam int unsigned FILT_W = idx_w(FILTERS);

    logic              mac_start;
    logic              mac_ready;
    logic [ROW_W-1:0]  win_row;
    logic [COL_W-1:0]  win_col;
    logic [FILT_W-1:0] filt_idx;

    modport master (output mac_start, win_row, win_col, filt_idx, input mac_ready);
    modport slave  (input mac_start, win_row, win_col, filt_idx, output mac_ready);

endinterface

// File: rtl/mac_idx_counter.sv
// Three-level job index counter: column fastest, then row, then filter.
// Holds at the final position; o_last flags that the current job is the last.
module mac_idx_counter
    import cnn_pkg::*;
#(
    parameter int unsigned OUT_W   = 3,
    parameter int unsigned OUT_H   = 3,
    parameter int unsigned FILTERS = 2,
    localparam int unsigned COL_W  = idx_w(OUT_W),
    localparam int unsigned ROW_W  = idx_w(OUT_H),
    localparam int unsigned FILT_W = idx_w(FILTERS)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic [FILT_W-1:0] o_filt,
    output logic              o_last
);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(OUT_H - 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTERS - 1);

    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [FILT_W-1:0] r_filt;
    logic              w_col_max;
    logic              w_row_max;
    logic              w_filt_max;
    logic              w_last;

    assign w_col_max  = (r_col == COL_MAX);
    assign w_row_max  = (r_row == ROW_MAX);
    assign w_filt_max = (r_filt == FILT_MAX);
    assign w_last     = w_col_max && w_row_max && w_filt_max;

    // Carry-chained increment; the final position holds instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_row  <= '0;
            r_col  <= '0;
            r_filt <= '0;
        end else if (i_inc && !w_last) begin
            if (!w_col_max) begin
                r_col <= r_col + 1'b1;
            end else begin
                r_col <= '0;
                if (!w_row_max) begin
                    r_row <= r_row + 1'b1;
                end else begin
                    r_row  <= '0;
                    r_filt <= r_filt + 1'b1;
                end
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_filt = r_filt;
    assign o_last = w_last;

endmodule

// File: rtl/mac_job_ctrl.sv
// MAC job initiator: on go, walks every window position of every filter,
// pulses mac_start once per job and waits for mac_ready before advancing.
// Optional feature macro: MAC_TIMEOUT_EN (per-job WAIT timeout with sticky err).
module mac_job_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned IMG_W   = 6,
    parameter int unsigned IMG_H   = 6,
    parameter int unsigned FILTERS = 2,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    localparam int unsigned OUT_W  = out_dim(IMG_W, N),
    localparam int unsigned OUT_H  = out_dim(IMG_H, N),
    localparam int unsigned JOBS   = job_count(OUT_W, OUT_H, FILTERS),
    localparam int unsigned JD_W   = idx_w(JOBS + 1)
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    output logic            busy,
    output logic            done,
    output logic            err,
    mac_job_ctrl_if.master  mac,
    output logic [JD_W-1:0] jobs_done
);

    localparam int unsigned ROW_W  = idx_w(OUT_H);
    localparam int unsigned COL_W  = idx_w(OUT_W);
    localparam int unsigned FILT_W = idx_w(FILTERS);

    state_t            r_state;
    state_t            w_next;
    logic [JD_W-1:0]   r_jobs;
    logic              w_clr;
    logic              w_inc;
    logic              w_last;
    logic              w_timeout;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic [FILT_W-1:0] w_filt;

    assign w_clr = (r_state == ST_IDLE) && go;
    assign w_inc = (r_state == ST_ADVANCE);

    mac_idx_counter #(
        .OUT_W   (OUT_W),
        .OUT_H   (OUT_H),
        .FILTERS (FILTERS)
    ) u_idx (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_filt (w_filt),
        .o_last (w_last)
    );

`ifdef MAC_TIMEOUT_EN
    localparam int unsigned CNT_W = idx_w(TIMEOUT);

    logic [CNT_W-1:0] r_wcnt;
    logic             r_err;

    // Timeout fires on the TIMEOUT-th consecutive WAIT cycle without ready.
    assign w_timeout = (r_state == ST_WAIT) && !mac.mac_ready &&
                       (r_wcnt == CNT_W'(TIMEOUT - 1));

    // WAIT-cycle counter, cleared in GUARD so it starts at 0 on WAIT entry.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_GUARD)) begin
            r_wcnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only when a new run is accepted.
    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic for the job walk.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (go) w_next = ST_ISSUE;
            ST_ISSUE:   w_next = ST_GUARD;
            ST_GUARD:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (mac.mac_ready)  w_next = ST_ADVANCE;
                else if (w_timeout) w_next = ST_FIN;
            end
            ST_ADVANCE: w_next = w_last ? ST_FIN : ST_ISSUE;
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completed-job count for the current run.
    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_jobs <= '0;
        end else if (w_inc) begin
            r_jobs <= r_jobs + 1'b1;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_FIN);
    assign mac.mac_start = (r_state == ST_ISSUE);
    assign mac.win_row   = w_row;
    assign mac.win_col   = w_col;
    assign mac.filt_idx  = w_filt;
    assign jobs_done     = r_jobs;

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Directed self-checking bench for mac_job_ctrl: default geometry
// (6x6 image, 4x4 kernel, 2 filters) plus a single-job 4x4 instance.
module tb_mac_job_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       go2;
    logic       busy, done, err;
    logic       busy2, done2, err2;
    logic [4:0] jobs_done;
    logic [0:0] jobs2;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: ready 3 cycles after start, 1: ready held high, 2: never ready
    int mcnt   = 0;

    mac_job_ctrl_if #(.N(4), .IMG_W(6), .IMG_H(6), .FILTERS(2)) mif ();
    mac_job_ctrl_if #(.N(4), .IMG_W(4), .IMG_H(4), .FILTERS(1)) mif2 ();

    mac_job_ctrl #(.N(4), .IMG_W(6), .IMG_H(6), .FILTERS(2), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mac       (mif.master),
        .jobs_done (jobs_done)
    );

    mac_job_ctrl #(.N(4), .IMG_W(4), .IMG_H(4), .FILTERS(1), .TIMEOUT(16)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .go        (go2),
        .busy      (busy2),
        .done      (done2),
        .err       (err2),
        .mac       (mif2.master),
        .jobs_done (jobs2)
    );

    always #5 clk = ~clk;

    // MAC model for the main instance, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            mif.mac_ready = (mode == 1);
            mcnt = 0;
        end else if (mode == 1) begin
            mif.mac_ready = 1'b1;
        end else if (mif.mac_start) begin
            mif.mac_ready = 1'b0;
            mcnt = 3;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0 && mode == 0) mif.mac_ready = 1'b1;
        end
    end

    task automatic do_reset;
        reset = 1'b1;
        go    = 1'b0;
        go2   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_go;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        do_reset();
        checks++;
        if ({busy, done, err, mif.mac_start} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_ctl got %b want 0000", {busy, done, err, mif.mac_start});
        end
        checks++;
        if ({mif.win_row, mif.win_col, mif.filt_idx} !== 5'b0) begin
            errors++;
            $display("FAIL rst_idx got %b want 00000", {mif.win_row, mif.win_col, mif.filt_idx});
        end
        checks++;
        if (jobs_done !== 5'd0) begin
            errors++;
            $display("FAIL rst_jobs got %0d want 0", jobs_done);
        end
        // Reset during WAIT of job 5.
        mode = 0;
        n = 0;
        pulse_go();
        for (int t = 0; t < 200 && n < 5; t++) begin
            if (mif.mac_start) n++;
            if (n < 5) @(negedge clk);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL midwait_reach got %0d starts want 5", n);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, mif.mac_start} !== 4'b0000) begin
            errors++;
            $display("FAIL midwait_ctl got %b want 0000", {busy, done, err, mif.mac_start});
        end
        checks++;
        if ({mif.win_row, mif.win_col, mif.filt_idx} !== 5'b0) begin
            errors++;
            $display("FAIL midwait_idx got %b want 00000", {mif.win_row, mif.win_col, mif.filt_idx});
        end
        checks++;
        if (jobs_done !== 5'd0) begin
            errors++;
            $display("FAIL midwait_jobs got %0d want 0", jobs_done);
        end
        reset = 1'b0;
        pulse_go();
        checks++;
        if ({mif.mac_start, mif.win_row, mif.win_col, mif.filt_idx} !== 6'b100000) begin
            errors++;
            $display("FAIL restart got %b want 100000",
                     {mif.mac_start, mif.win_row, mif.win_col, mif.filt_idx});
        end
    endtask

    task automatic test_sequence;
        logic [1:0] er, ec;
        logic       ef;
        int n, jd;
        bit seen;
        do_reset();
        mode = 0; er = 2'd0; ec = 2'd0; ef = 1'b0; n = 0; jd = 0; seen = 1'b0;
        pulse_go();
        for (int t = 0; t < 400 && !seen; t++) begin
            if (mif.mac_start) begin
                checks++;
                if ({mif.win_row, mif.win_col, mif.filt_idx} !== {er, ec, ef}) begin
                    errors++;
                    $display("FAIL seq_idx job %0d got r%0d c%0d f%0d want r%0d c%0d f%0d",
                             n, mif.win_row, mif.win_col, mif.filt_idx, er, ec, ef);
                end
                n++;
                if (ec == 2'd2) begin
                    ec = 2'd0;
                    if (er == 2'd2) begin er = 2'd0; ef = ~ef; end
                    else er = er + 2'd1;
                end else ec = ec + 2'd1;
            end
            if (done) begin seen = 1'b1; jd = int'(jobs_done); end
            @(negedge clk);
        end
        checks++;
        if (!seen || n != 18) begin
            errors++;
            $display("FAIL seq_starts got %0d (done=%0d) want 18", n, seen);
        end
        checks++;
        if (jd != 18) begin
            errors++;
            $display("FAIL seq_jobs got %0d want 18", jd);
        end
        checks++;
        if ({done, busy, err} !== 3'b000) begin
            errors++;
            $display("FAIL seq_after got done/busy/err %b want 000", {done, busy, err});
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] er, ec;
        logic       ef;
        int n, last_t;
        bit seen;
        mode = 1;
        do_reset();
        er = 2'd0; ec = 2'd0; ef = 1'b0; n = 0; last_t = 0; seen = 1'b0;
        pulse_go();
        for (int t = 0; t < 400 && !seen; t++) begin
            if (mif.mac_start) begin
                if (n > 0) begin
                    checks++;
                    if (t - last_t != 4) begin
                        errors++;
                        $display("FAIL b2b_gap job %0d got %0d want 4", n, t - last_t);
                    end
                end
                checks++;
                if ({mif.win_row, mif.win_col, mif.filt_idx, jobs_done} !== {er, ec, ef, 5'(n)}) begin
                    errors++;
                    $display("FAIL b2b_idx job %0d got r%0d c%0d f%0d j%0d want r%0d c%0d f%0d j%0d",
                             n, mif.win_row, mif.win_col, mif.filt_idx, jobs_done, er, ec, ef, n);
                end
                last_t = t;
                n++;
                if (ec == 2'd2) begin
                    ec = 2'd0;
                    if (er == 2'd2) begin er = 2'd0; ef = ~ef; end
                    else er = er + 2'd1;
                end else ec = ec + 2'd1;
            end
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!seen || n != 18) begin
            errors++;
            $display("FAIL b2b_starts got %0d (done=%0d) want 18", n, seen);
        end
        mode = 0;
    endtask

    task automatic test_go_ignored;
        logic [1:0] er, ec;
        logic       ef;
        int n, jd, extra;
        bit seen;
        do_reset();
        mode = 0; er = 2'd0; ec = 2'd0; ef = 1'b0; n = 0; jd = 0; extra = 0; seen = 1'b0;
        pulse_go();
        for (int t = 0; t < 400 && !seen; t++) begin
            if (go) go = 1'b0;
            if (mif.mac_start) begin
                checks++;
                if ({mif.win_row, mif.win_col, mif.filt_idx} !== {er, ec, ef}) begin
                    errors++;
                    $display("FAIL goign_idx job %0d got r%0d c%0d f%0d want r%0d c%0d f%0d",
                             n, mif.win_row, mif.win_col, mif.filt_idx, er, ec, ef);
                end
                n++;
                if (n == 7) go = 1'b1;
                if (ec == 2'd2) begin
                    ec = 2'd0;
                    if (er == 2'd2) begin er = 2'd0; ef = ~ef; end
                    else er = er + 2'd1;
                end else ec = ec + 2'd1;
            end
            if (done) begin seen = 1'b1; jd = int'(jobs_done); end
            @(negedge clk);
        end
        go = 1'b0;
        checks++;
        if (!seen || n != 18 || jd != 18) begin
            errors++;
            $display("FAIL goign_run got starts %0d jobs %0d want 18 18", n, jd);
        end
        for (int t = 0; t < 10; t++) begin
            if (busy || mif.mac_start) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL goign_queued got %0d busy cycles want 0", extra);
        end
    endtask

`ifdef MAC_TIMEOUT_EN
    task automatic test_timeout;
        int n, s, dt;
        bit seen;
        do_reset();
        mode = 0; n = 0; s = 0; dt = 0; seen = 1'b0;
        pulse_go();
        for (int t = 0; t < 300 && !seen; t++) begin
            if (mif.mac_start) begin
                n++;
                if (n == 4) begin mode = 2; s = t; end
            end
            if (done) begin
                seen = 1'b1;
                dt = t - s;
                checks++;
                if ({err, jobs_done} !== {1'b1, 5'd3}) begin
                    errors++;
                    $display("FAIL to_state got err %b jobs %0d want err 1 jobs 3", err, jobs_done);
                end
                checks++;
                if ({mif.win_row, mif.win_col, mif.filt_idx} !== {2'd1, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL to_idx got r%0d c%0d f%0d want r1 c0 f0",
                             mif.win_row, mif.win_col, mif.filt_idx);
                end
            end
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen || dt != 18) begin
            errors++;
            $display("FAIL to_timing got done %0d cycles after start (seen=%0d) want 18", dt, seen);
        end
        @(negedge clk);
        mode = 0;
        pulse_go();
        checks++;
        if ({err, mif.mac_start} !== 2'b01) begin
            errors++;
            $display("FAIL to_clear got err/start %b want 01", {err, mif.mac_start});
        end
        do_reset();
    endtask
`else
    task automatic test_no_timeout;
        int dn;
        mode = 2;
        do_reset();
        dn = 0;
        pulse_go();
        for (int t = 0; t < 100; t++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0 || {busy, err, jobs_done} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL nto_wait got done %0d busy %b err %b jobs %0d want 0 1 0 0",
                     dn, busy, err, jobs_done);
        end
        mode = 0;
        do_reset();
    endtask
`endif

    task automatic test_single_job;
        int n, jd, dt;
        bit seen;
        do_reset();
        mif2.mac_ready = 1'b0;
        n = 0; jd = 0; dt = 0; seen = 1'b0;
        go2 = 1'b1;
        @(negedge clk);
        go2 = 1'b0;
        checks++;
        if ({mif2.mac_start, mif2.win_row, mif2.win_col, mif2.filt_idx} !== 4'b1000) begin
            errors++;
            $display("FAIL one_start got %b want 1000",
                     {mif2.mac_start, mif2.win_row, mif2.win_col, mif2.filt_idx});
        end
        for (int t = 0; t < 50 && !seen; t++) begin
            if (mif2.mac_start) n++;
            if (t == 4) mif2.mac_ready = 1'b1;
            if (done2) begin seen = 1'b1; dt = t; jd = int'(jobs2); end
            @(negedge clk);
        end
        mif2.mac_ready = 1'b0;
        checks++;
        if (!seen || n != 1 || dt != 6) begin
            errors++;
            $display("FAIL one_run got starts %0d done_at %0d (seen=%0d) want 1 6", n, dt, seen);
        end
        checks++;
        if (jd != 1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL one_end got jobs %0d busy %b want 1 0", jd, busy2);
        end
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        go2   = 1'b0;
        mif2.mac_ready = 1'b0;
        test_reset();
        test_sequence();
        test_back_to_back();
        test_go_ignored();
`ifdef MAC_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_single_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
